// File: rtl/vga_raster_if.sv
// vga_raster_if: pixel-source and DAC-side signals of the raster generator.
// master = vga_raster (drives position/pins), slave = game logic / pins.
interface vga_raster_if;
    logic [7:0]  Pixel;
    logic [11:0] Column;
    logic [11:0] Row;
    logic        HSync;
    logic        VSync;
    logic [2:0]  Red;
    logic [2:0]  Green;
    logic [1:0]  Blue;
    logic        FrameStart;

    modport master (
        input  Pixel,
        output Column, Row, HSync, VSync,
        output Red, Green, Blue, FrameStart
    );

    modport slave (
        output Pixel,
        input  Column, Row, HSync, VSync,
        input  Red, Green, Blue, FrameStart
    );
endinterface

// File: rtl/vga_raster.sv
// vga_raster: VGA raster timing generator. Scans hc/vc, publishes them on
// Column/Row, samples the RRRGGGBB Pixel and registers RGB + syncs.
// Ports: CLK_100MHz, RST_n (sync, active-low), vga (vga_raster_if.master:
//   Pixel in; Column, Row, HSync, VSync, Red, Green, Blue, FrameStart out),
//   PatternSel in (only with VGA_TEST_PATTERN_EN defined: colour-bar source).
module vga_raster #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter int   PIX_DIV  = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         CLK_100MHz,
    input  logic         RST_n,
    vga_raster_if.master vga
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic         PatternSel
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [11:0]      hc;
    logic [11:0]      vc;
    logic             pe;
    logic             h_wrap;
    logic             v_wrap;
    logic             vis;
    logic             hs;
    logic             vs;
    logic [7:0]       pix;

    logic [2:0]       red_q;
    logic [2:0]       green_q;
    logic [1:0]       blue_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             fs_q;

    // With PIX_DIV=1 the divider is stuck at 0 == DIV_LAST, so pe is constant 1.
    assign pe     = (div == DIV_LAST);
    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);
    assign vis    = (hc < H_VIS) && (vc < V_VIS);
    assign hs     = (hc >= HS_BEG) && (hc < HS_END);
    assign vs     = (vc >= VS_BEG) && (vc < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    logic [7:0] bar;

    // Eight 128-pixel-wide bars indexed by hc[9:7].
    always_comb begin
        bar = 8'h00;
        case (hc[9:7])
            3'd0:    bar = 8'hFF;
            3'd1:    bar = 8'hFC;
            3'd2:    bar = 8'h1F;
            3'd3:    bar = 8'h1C;
            3'd4:    bar = 8'hE3;
            3'd5:    bar = 8'hE0;
            3'd6:    bar = 8'h03;
            default: bar = 8'h00;
        endcase
    end

    assign pix = PatternSel ? bar : vga.Pixel;
`else
    assign pix = vga.Pixel;
`endif

    always_ff @(posedge CLK_100MHz) begin
        if (!RST_n) begin
            div <= '0;
        end else if (pe) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!RST_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pe) begin
            if (h_wrap) begin
                hc <= '0;
                vc <= v_wrap ? 12'd0 : vc + 12'd1;
            end else begin
                hc <= hc + 12'd1;
            end
        end
    end

    // Colour and syncs share one register stage so they stay aligned.
    always_ff @(posedge CLK_100MHz) begin
        if (!RST_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= pe && h_wrap && v_wrap;
            if (pe) begin
                red_q   <= vis ? pix[7:5] : 3'd0;
                green_q <= vis ? pix[4:2] : 3'd0;
                blue_q  <= vis ? pix[1:0] : 2'd0;
                hsync_q <= hs ? SYNC_POL : ~SYNC_POL;
                vsync_q <= vs ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga.Column     = hc;
    assign vga.Row        = vc;
    assign vga.Red        = red_q;
    assign vga.Green      = green_q;
    assign vga.Blue       = blue_q;
    assign vga.HSync      = hsync_q;
    assign vga.VSync      = vsync_q;
    assign vga.FrameStart = fs_q;

endmodule
